cu_run_controller: RTL

Run/step sequencer for the microprogrammed control unit. It generates the CPU start, step-execution and next-instruction stimulus controls for the CAR sequencing logic, and watches the CAR value to detect instruction boundaries. It also handles operator start/stop/step requests, a PC breakpoint, halt detection and a retired-instruction counter.
It sits between the board/UART command front-end and the control unit.

---
 rtl/cu_run_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cu_run_controller.sv
// Run/step sequencer for the microprogrammed control unit: drives CAR start/step
// controls, detects instruction boundaries, and handles breakpoint, halt and counting.
module cu_run_controller #(
    parameter int unsigned            CAR_W      = 7,
    parameter int unsigned            PC_W       = 8,
    parameter int unsigned            CNT_W      = 16,
    parameter logic [CAR_W-1:0]       FETCH_ADDR = 7'h00
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_req,
    input  logic             i_stop_req,
    input  logic             i_step_req,
    input  logic             i_mode_step,
    input  logic             i_halt,
    input  logic [CAR_W-1:0] i_car_data,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_bp_en,
    input  logic [PC_W-1:0]  i_bp_addr,
    output logic             o_cpu_start,
    output logic             o_step_execution,
    output logic             o_next_instr_stimulus,
    output logic             o_halted,
    output logic             o_bp_hit,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PARK    = 3'd2,
        S_STEP_GO = 3'd3,
        S_HALTED  = 3'd4,
        S_RESTART = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CAR_W-1:0]   car_prev_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               bp_hit_q, bp_hit_d;
    logic               cpu_start_q, step_exec_q, stim_q, halted_q;
    logic               bnd;
    logic               bp_match;

    // A boundary is the CAR re-entering the fetch address from elsewhere.
    assign bnd      = (i_car_data == FETCH_ADDR) && (car_prev_q != FETCH_ADDR);
    assign bp_match = bnd && i_bp_en && (i_pc == i_bp_addr);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        bp_hit_d = bp_hit_q;

        if ((state_q == S_RUN || state_q == S_STEP_GO) && bnd && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start_req && !i_stop_req) begin
                    count_d  = '0;
                    bp_hit_d = 1'b0;
                    state_d  = i_mode_step ? S_PARK : S_RUN;
                end
            end
            S_RUN: begin
                if (i_stop_req) begin
                    state_d = S_IDLE;
                end else if (i_halt) begin
                    state_d = S_HALTED;
                end else if (bp_match) begin
                    state_d  = S_PARK;
                    bp_hit_d = 1'b1;
                end else if (i_mode_step) begin
                    state_d = S_PARK;
                end
            end
            S_PARK: begin
                if (i_stop_req) begin
                    state_d = S_IDLE;
                end else if (i_halt) begin
                    state_d = S_HALTED;
                end else if (i_step_req) begin
                    state_d = S_STEP_GO;
                end else if (!i_mode_step) begin
                    state_d  = S_RUN;
                    bp_hit_d = 1'b0;
                end
            end
            S_STEP_GO: begin
                // Further step requests are dropped here; only bnd returns to PARK.
                if (i_stop_req) begin
                    state_d = S_IDLE;
                end else if (i_halt) begin
                    state_d = S_HALTED;
                end else if (bnd) begin
                    state_d = S_PARK;
                end
            end
            S_HALTED: begin
                if (i_stop_req) begin
                    state_d = S_IDLE;
                end else if (i_start_req) begin
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                count_d = '0;
                if (i_stop_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = i_mode_step ? S_PARK : S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            car_prev_q <= FETCH_ADDR;
            count_q    <= '0;
            bp_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            car_prev_q <= i_car_data;
            count_q    <= count_d;
            bp_hit_q   <= bp_hit_d;
        end
    end

    // Control levels are decoded from the current state and registered, so they
    // trail the state by one cycle; RESTART thus yields a single low cpu_start cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cpu_start_q <= 1'b0;
            step_exec_q <= 1'b0;
            stim_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            cpu_start_q <= (state_q == S_RUN) || (state_q == S_PARK) ||
                           (state_q == S_STEP_GO) || (state_q == S_HALTED);
            step_exec_q <= (state_q == S_PARK) || (state_q == S_STEP_GO);
            stim_q      <= (state_q == S_STEP_GO);
            halted_q    <= (state_q == S_HALTED);
        end
    end

    assign o_cpu_start           = cpu_start_q;
    assign o_step_execution      = step_exec_q;
    assign o_next_instr_stimulus = stim_q;
    assign o_halted              = halted_q;
    assign o_bp_hit              = bp_hit_q;
    assign o_instr_count         = count_q;
    assign o_state               = state_q;

endmodule
